// File: rtl/pc_seq_pkg.sv
// Shared types and helpers for the fetch-stage PC sequencer.
// Optional misalignment trap is enabled by defining PC_SEQ_MISALIGN_TRAP_EN.
package pc_seq_pkg;

    localparam int DEF_XLEN        = 32;
    localparam int DEF_INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } pc_seq_state_e;

    // Mask keeping the bits above the instruction granule; callers slice to XLEN.
    function automatic logic [63:0] align_mask(input int unsigned instr_bytes);
        logic [63:0] low_bits;
        low_bits = 64'(instr_bytes) - 64'd1;
        return ~low_bits;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle of the PC sequencer: redirect requests, freeze and the PC handshake.
// Used by pc_sequencer (with or without PC_SEQ_MISALIGN_TRAP_EN).
interface pc_sequencer_if
    import pc_seq_pkg::*;
#(
    parameter int XLEN    = DEF_XLEN,
    parameter int NUM_SRC = 3
);
    logic                    hold;
    logic [NUM_SRC-1:0]      redirect_valid;
    logic [NUM_SRC*XLEN-1:0] redirect_target;
    logic                    pc_ready;
    logic [XLEN-1:0]         pc;
    logic                    pc_valid;
    logic                    flush;
    logic                    misalign;

    modport master (
        input  hold, redirect_valid, redirect_target, pc_ready,
        output pc, pc_valid, flush, misalign
    );

    modport slave (
        output hold, redirect_valid, redirect_target, pc_ready,
        input  pc, pc_valid, flush, misalign
    );
endinterface

// File: rtl/pc_sequencer_redirect_arbiter.sv
// Fixed-priority selector: lowest requesting index wins, purely combinational.
// Independent of PC_SEQ_MISALIGN_TRAP_EN.
module redirect_arbiter
    import pc_seq_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int XLEN    = DEF_XLEN,
    parameter int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0]      req,
    input  logic [NUM_SRC*XLEN-1:0] target_flat,
    output logic [NUM_SRC-1:0]      grant,
    output logic [IDX_W-1:0]        idx,
    output logic                    any_valid,
    output logic [XLEN-1:0]         target
);

    // Scan from the lowest priority upward so the last hit is the winner.
    always_comb begin
        grant  = '0;
        idx    = '0;
        target = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                idx      = IDX_W'(i);
                target   = target_flat[i*XLEN +: XLEN];
            end
        end
    end

    assign any_valid = |req;

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC generator and PC register with prioritised redirects and a pending slot across freezes.
// Define PC_SEQ_MISALIGN_TRAP_EN to trap misaligned targets instead of clearing their low bits.
//
// state | meaning
// BOOT  | one cycle after reset, pc not yet presented, redirects ignored
// RUN   | pc presented, advances on pc_ready or jumps on a redirect
// HOLD  | pipeline frozen, pc not presented, best redirect kept in pending
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              XLEN         = DEF_XLEN,
    parameter int              NUM_SRC      = 3,
    parameter int              INSTR_BYTES  = DEF_INSTR_BYTES,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
) (
    input  logic            clk,
    input  logic            rst_n,
    pc_sequencer_if.master  sq
);

    localparam int              IDX_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [63:0]     MASK64     = align_mask(INSTR_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = MASK64[XLEN-1:0];

    pc_seq_state_e    state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic             pc_valid_q, pc_valid_d;
    logic             flush_q, flush_d;
    logic             misalign_q, misalign_d;
    logic             pend_valid_q, pend_valid_d;
    logic [IDX_W-1:0] pend_idx_q, pend_idx_d;
    logic [XLEN-1:0]  pend_tgt_q, pend_tgt_d;

    logic [NUM_SRC-1:0] live_grant;
    logic [IDX_W-1:0]   live_idx;
    logic               live_any;
    logic [XLEN-1:0]    live_tgt;

    redirect_arbiter #(
        .NUM_SRC (NUM_SRC),
        .XLEN    (XLEN),
        .IDX_W   (IDX_W)
    ) u_live_arb (
        .req         (sq.redirect_valid),
        .target_flat (sq.redirect_target),
        .grant       (live_grant),
        .idx         (live_idx),
        .any_valid   (live_any),
        .target      (live_tgt)
    );

    // Live beats pending on a lower or equal source index; this also decides capture into pending.
    logic sel_live;
    assign sel_live = live_any && (!pend_valid_q || (live_idx <= pend_idx_q));

    logic [1:0]      mrg_grant;
    logic            mrg_idx;
    logic            mrg_any;
    logic [XLEN-1:0] mrg_tgt;

    redirect_arbiter #(
        .NUM_SRC (2),
        .XLEN    (XLEN),
        .IDX_W   (1)
    ) u_merge_arb (
        .req         ({pend_valid_q, sel_live}),
        .target_flat ({pend_tgt_q, live_tgt}),
        .grant       (mrg_grant),
        .idx         (mrg_idx),
        .any_valid   (mrg_any),
        .target      (mrg_tgt)
    );

    logic [XLEN-1:0] apply_pc;
    logic            apply_mis;

`ifdef PC_SEQ_MISALIGN_TRAP_EN
    always_comb begin
        apply_pc  = mrg_tgt;
        apply_mis = 1'b0;
        if ((mrg_tgt & ~ALIGN_MASK) != '0) begin
            apply_pc  = TRAP_VECTOR;
            apply_mis = 1'b1;
        end
    end

    logic unused_arb;
    assign unused_arb = ^{live_grant, mrg_grant, mrg_idx};
`else
    assign apply_pc  = mrg_tgt & ALIGN_MASK;
    assign apply_mis = 1'b0;

    logic unused_arb;
    assign unused_arb = ^{live_grant, mrg_grant, mrg_idx, TRAP_VECTOR};
`endif

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pc_valid_d   = pc_valid_q;
        flush_d      = 1'b0;
        misalign_d   = 1'b0;
        pend_valid_d = pend_valid_q;
        pend_idx_d   = pend_idx_q;
        pend_tgt_d   = pend_tgt_q;

        unique case (state_q)
            BOOT: begin
                if (sq.hold) begin
                    state_d = HOLD;
                end else begin
                    state_d    = RUN;
                    pc_valid_d = 1'b1;
                end
            end

            RUN: begin
                if (sq.hold) begin
                    state_d    = HOLD;
                    pc_valid_d = 1'b0;
                    if (sel_live) begin
                        pend_valid_d = 1'b1;
                        pend_idx_d   = live_idx;
                        pend_tgt_d   = live_tgt;
                    end
                end else if (mrg_any) begin
                    pc_d       = apply_pc;
                    flush_d    = 1'b1;
                    misalign_d = apply_mis;
                end else if (sq.pc_ready) begin
                    pc_d = pc_q + XLEN'(INSTR_BYTES);
                end
            end

            HOLD: begin
                if (sq.hold) begin
                    if (sel_live) begin
                        pend_valid_d = 1'b1;
                        pend_idx_d   = live_idx;
                        pend_tgt_d   = live_tgt;
                    end
                end else begin
                    state_d      = RUN;
                    pc_valid_d   = 1'b1;
                    pend_valid_d = 1'b0;
                    if (mrg_any) begin
                        pc_d       = apply_pc;
                        flush_d    = 1'b1;
                        misalign_d = apply_mis;
                    end
                end
            end

            default: begin
                state_d      = BOOT;
                pc_valid_d   = 1'b0;
                pend_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= BOOT;
            pc_q         <= RESET_VECTOR;
            pc_valid_q   <= 1'b0;
            flush_q      <= 1'b0;
            misalign_q   <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_idx_q   <= '0;
            pend_tgt_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pc_valid_q   <= pc_valid_d;
            flush_q      <= flush_d;
            misalign_q   <= misalign_d;
            pend_valid_q <= pend_valid_d;
            pend_idx_q   <= pend_idx_d;
            pend_tgt_q   <= pend_tgt_d;
        end
    end

    assign sq.pc       = pc_q;
    assign sq.pc_valid = pc_valid_q;
    assign sq.flush    = flush_q;
    assign sq.misalign = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer; expectations follow PC_SEQ_MISALIGN_TRAP_EN when defined.
module tb_pc_sequencer;

    localparam int XLEN    = 32;
    localparam int NUM_SRC = 3;

`ifdef PC_SEQ_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pc_sequencer_if #(.XLEN(XLEN), .NUM_SRC(NUM_SRC)) bus ();

    pc_sequencer #(
        .XLEN         (XLEN),
        .NUM_SRC      (NUM_SRC),
        .INSTR_BYTES  (4),
        .RESET_VECTOR (32'h0000_0000),
        .TRAP_VECTOR  (32'h0000_0100)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sq    (bus.master)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic        valid;
        logic        flush;
        logic        mis;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue what the outputs must be after the edge, then compare.
    task automatic step(input logic rn, input logic h, input logic [2:0] rv,
                        input logic [31:0] t0, input logic [31:0] t1, input logic [31:0] t2,
                        input logic rdy, input logic [31:0] e_pc, input logic e_v,
                        input logic e_f, input logic e_m, input string tag);
        exp_t e;
        rst_n               = rn;
        bus.hold            = h;
        bus.redirect_valid  = rv;
        bus.redirect_target = {t2, t1, t0};
        bus.pc_ready        = rdy;
        sb_q.push_back('{pc: e_pc, valid: e_v, flush: e_f, mis: e_m});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check({tag, "/pc"},       bus.pc,                e.pc);
        check({tag, "/pc_valid"}, 32'(bus.pc_valid),     32'(e.valid));
        check({tag, "/flush"},    32'(bus.flush),        32'(e.flush));
        check({tag, "/misalign"}, 32'(bus.misalign),     32'(e.mis));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] p_mis, p_mis_next, p_pend;
        p_mis      = TRAP_EN ? 32'h0000_0100 : 32'h0000_1000;
        p_mis_next = p_mis + 32'd4;
        p_pend     = TRAP_EN ? 32'h0000_0100 : 32'h0000_2004;

        //   rn h  rv      t0            t1          t2          rdy  e_pc          v  f  m
        step(0, 0, 3'b000, 32'h0,        32'h0,      32'h0,      1,   32'h0,        0, 0, 0, "rst0");
        step(0, 0, 3'b001, 32'h999,      32'h0,      32'h0,      1,   32'h0,        0, 0, 0, "rst_redir");
        step(1, 0, 3'b001, 32'h700,      32'h0,      32'h0,      1,   32'h0,        1, 0, 0, "boot_ignore");
        step(1, 0, 3'b000, 32'h0,        32'h0,      32'h0,      1,   32'h4,        1, 0, 0, "inc4");
        step(1, 0, 3'b000, 32'h0,        32'h0,      32'h0,      1,   32'h8,        1, 0, 0, "inc8");
        step(1, 0, 3'b000, 32'h0,        32'h0,      32'h0,      1,   32'hC,        1, 0, 0, "inc12");
        step(1, 0, 3'b000, 32'h0,        32'h0,      32'h0,      0,   32'hC,        1, 0, 0, "stall");
        step(1, 0, 3'b100, 32'h0,        32'h0,      32'h40,     0,   32'h40,       1, 1, 0, "redir_noready");
        step(1, 0, 3'b110, 32'h0,        32'h200,    32'h300,    1,   32'h200,      1, 1, 0, "prio");
        step(1, 0, 3'b000, 32'h0,        32'h0,      32'h0,      1,   32'h204,      1, 0, 0, "post_redir");
        step(1, 0, 3'b001, 32'hFFFF_FFFC,32'h0,      32'h0,      1,   32'hFFFF_FFFC,1, 1, 0, "to_top");
        step(1, 0, 3'b000, 32'h0,        32'h0,      32'h0,      1,   32'h0,        1, 0, 0, "wrap");
        step(1, 1, 3'b100, 32'h0,        32'h0,      32'h500,    1,   32'h0,        0, 0, 0, "hold_src2");
        step(1, 1, 3'b001, 32'h800,      32'h0,      32'h0,      1,   32'h0,        0, 0, 0, "hold_src0");
        step(1, 1, 3'b010, 32'h0,        32'h900,    32'h0,      1,   32'h0,        0, 0, 0, "hold_src1");
        step(1, 0, 3'b000, 32'h0,        32'h0,      32'h0,      1,   32'h800,      1, 1, 0, "release");
        step(1, 0, 3'b000, 32'h0,        32'h0,      32'h0,      1,   32'h804,      1, 0, 0, "after_release");
        step(1, 1, 3'b010, 32'h0,        32'h600,    32'h0,      1,   32'h804,      0, 0, 0, "hold_pend1");
        step(1, 0, 3'b010, 32'h0,        32'h700,    32'h0,      1,   32'h700,      1, 1, 0, "tie_live");
        step(1, 1, 3'b100, 32'h0,        32'h0,      32'hA00,    1,   32'h700,      0, 0, 0, "hold_pend2");
        step(1, 0, 3'b010, 32'h0,        32'hB00,    32'h0,      1,   32'hB00,      1, 1, 0, "live_better");
        step(1, 1, 3'b000, 32'h0,        32'h0,      32'h0,      1,   32'hB00,      0, 0, 0, "hold_empty");
        step(1, 0, 3'b000, 32'h0,        32'h0,      32'h0,      0,   32'hB00,      1, 0, 0, "release_empty");
        step(1, 0, 3'b001, 32'h1002,     32'h0,      32'h0,      1,   p_mis,        1, 1, TRAP_EN, "misalign");
        step(1, 0, 3'b000, 32'h0,        32'h0,      32'h0,      1,   p_mis_next,   1, 0, 0, "after_misalign");
        step(1, 1, 3'b010, 32'h0,        32'h2006,   32'h0,      1,   p_mis_next,   0, 0, 0, "hold_mis");
        step(1, 0, 3'b000, 32'h0,        32'h0,      32'h0,      1,   p_pend,       1, 1, TRAP_EN, "pend_misalign");
        step(1, 1, 3'b001, 32'h3000,     32'h0,      32'h0,      1,   p_pend,       0, 0, 0, "hold_pend3");
        step(0, 1, 3'b000, 32'h0,        32'h0,      32'h0,      1,   32'h0,        0, 0, 0, "rst_midhold");
        step(1, 1, 3'b001, 32'h4000,     32'h0,      32'h0,      1,   32'h0,        0, 0, 0, "boot_hold");
        step(1, 0, 3'b000, 32'h0,        32'h0,      32'h0,      1,   32'h0,        1, 0, 0, "release_after_boot");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
